// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with a sliding PAT_W-bit window,
// runtime overlap/non-overlap match mode and a saturating match counter.
// Optional feature macro: SEQ_DETECT_PROG_PATTERN_EN adds a runtime-loadable
// pattern register (ports pat_load / pat_in); otherwise PATTERN is a constant.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             overlap_en,
`ifdef SEQ_DETECT_PROG_PATTERN_EN
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`endif
    output logic [PAT_W-1:0] window,
    output logic             found,
    output logic [CNT_W-1:0] match_count,
    output logic             max_tick
);

    localparam int unsigned       FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [0:0] {StFill, StArmed} state_e;

    state_e            state;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  pat_value;
    logic [PAT_W-1:0]  next_window;
    logic              full_window;
    logic              hit;

`ifdef SEQ_DETECT_PROG_PATTERN_EN
    logic [PAT_W-1:0] pat_reg;
    assign pat_value = pat_reg;
`else
    assign pat_value = PATTERN;
`endif

    // Match is judged against the window as it will be after this beat's shift.
    always_comb begin
        next_window = {window[PAT_W-2:0], bit_in};
        full_window = (state == StArmed) || (fill == FILL_LAST);
        hit         = (next_window == pat_value) && full_window;
    end

    // Window, fill counter, FSM, match counter and registered pulses.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            window      <= '0;
            fill        <= '0;
            state       <= StFill;
            found       <= 1'b0;
            match_count <= '0;
            max_tick    <= 1'b0;
`ifdef SEQ_DETECT_PROG_PATTERN_EN
            pat_reg     <= PATTERN;
        end else if (pat_load) begin
            // New pattern restarts detection; the match count is kept.
            pat_reg     <= pat_in;
            window      <= '0;
            fill        <= '0;
            state       <= StFill;
            found       <= 1'b0;
            max_tick    <= 1'b0;
`endif
        end else if (bit_valid) begin
            window   <= next_window;
            found    <= hit;
            // Fires only on the increment that lands on the maximum.
            max_tick <= hit && (match_count == CNT_MAX - CNT_W'(1));
            if (hit && (match_count != CNT_MAX)) begin
                match_count <= match_count + CNT_W'(1);
            end
            if (hit && !overlap_en) begin
                // Non-overlap: the next match needs PAT_W fresh bits.
                fill  <= '0;
                state <= StFill;
            end else begin
                if (fill != FILL_LAST) begin
                    fill <= fill + FILL_W'(1);
                end
                if (full_window) begin
                    state <= StArmed;
                end
            end
        end else begin
            found    <= 1'b0;
            max_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param (PAT_W=4, PATTERN=1011, CNT_W=3).
// A reference model pushes the expected outputs for every cycle into a
// scoreboard queue; the entry is popped and compared after the clock edge.
module tb_seq_detect_param;

    localparam int unsigned PAT_W   = 4;
    localparam logic [3:0]  PATTERN = 4'b1011;
    localparam int unsigned CNT_W   = 3;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       overlap_en = 1'b1;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic [3:0] window;
    logic       found;
    logic [2:0] match_count;
    logic       max_tick;

    seq_detect_param #(
        .PAT_W  (PAT_W),
        .PATTERN(PATTERN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .overlap_en (overlap_en),
`ifdef SEQ_DETECT_PROG_PATTERN_EN
        .pat_load   (pat_load),
        .pat_in     (pat_in),
`endif
        .window     (window),
        .found      (found),
        .match_count(match_count),
        .max_tick   (max_tick)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic       found;
        logic       tick;
        logic [2:0] count;
        logic [3:0] win;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int n_found = 0;
    int n_tick = 0;

    // Reference model state: bits counts fresh bits, saturating at 4.
    logic [3:0] m_win = '0;
    int         m_bits = 0;
    int         m_cnt = 0;
    logic [3:0] m_pat = PATTERN;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model the expectation, push it, drive, clock, pop and compare.
    task automatic cycle(input logic rst, input logic ld, input logic v, input logic b,
                         input logic ov, input logic [3:0] pin);
        exp_t e;
        e.found = 1'b0;
        e.tick  = 1'b0;
        if (rst) begin
            m_win  = '0;
            m_bits = 0;
            m_cnt  = 0;
            m_pat  = PATTERN;
        end else if (ld) begin
            m_pat  = pin;
            m_win  = '0;
            m_bits = 0;
        end else if (v) begin
            m_win = {m_win[2:0], b};
            if (m_bits < 4) m_bits++;
            if (m_win == m_pat && m_bits == 4) begin
                e.found = 1'b1;
                if (m_cnt < 7) begin
                    m_cnt++;
                    e.tick = (m_cnt == 7);
                end
                if (!ov) m_bits = 0;
            end
        end
        e.count = 3'(m_cnt);
        e.win   = m_win;
        exp_q.push_back(e);

        reset      = rst;
        pat_load   = ld;
        bit_valid  = v;
        bit_in     = b;
        overlap_en = ov;
        pat_in     = pin;
        @(posedge clk_in);
        #1;
        e = exp_q.pop_front();
        check("found", 32'(found), 32'(e.found));
        check("max_tick", 32'(max_tick), 32'(e.tick));
        check("match_count", 32'(match_count), 32'(e.count));
        check("window", 32'(window), 32'(e.win));
        if (found === 1'b1) n_found++;
        if (max_tick === 1'b1) n_tick++;
    endtask

    task automatic beat(input logic b, input logic ov);
        cycle(1'b0, 1'b0, 1'b1, b, ov, 4'b0000);
    endtask

    task automatic idle(input logic b);
        cycle(1'b0, 1'b0, 1'b0, b, 1'b1, 4'b0000);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
        n_found = 0;
        n_tick  = 0;
    endtask

    task automatic stream(input logic [15:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) beat(bits[i], ov);
    endtask

    initial begin
        #1;
        // Reset state.
        do_reset();
        do_reset();
        check("reset_count", 32'(match_count), 32'd0);

        // Overlap mode: 1,0,1,1,0,1,1.
        stream(16'b1011011, 7, 1'b1);
        check("ovl_found_n", 32'(n_found), 32'd2);
        check("ovl_count", 32'(match_count), 32'd2);
        check("ovl_window", 32'(window), 32'b1011);
        idle(1'b0);

        // Non-overlap mode, same stream.
        do_reset();
        stream(16'b1011011, 7, 1'b0);
        check("novl_found_n", 32'(n_found), 32'd1);
        check("novl_count", 32'(match_count), 32'd1);

        // Non-overlap: 1,0,1,1,1,0,1,1.
        do_reset();
        stream(16'b10111011, 8, 1'b0);
        check("novl2_found_n", 32'(n_found), 32'd2);
        check("novl2_count", 32'(match_count), 32'd2);

        // Valid gaps with bit_in toggling while idle.
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] p;
            p = 4'b1011;
            beat(p[i], 1'b1);
            if (i != 0) begin
                idle(1'b1);
                idle(1'b0);
                idle(1'b1);
            end
        end
        idle(1'b0);
        check("gap_found_n", 32'(n_found), 32'd1);
        check("gap_count", 32'(match_count), 32'd1);

        // Saturation: nine non-overlapping matches.
        do_reset();
        for (int k = 0; k < 9; k++) stream(16'b1011, 4, 1'b0);
        idle(1'b0);
        check("sat_found_n", 32'(n_found), 32'd9);
        check("sat_tick_n", 32'(n_tick), 32'd1);
        check("sat_count", 32'(match_count), 32'd7);

        // Overlap switched on mid-stream after a non-overlap match.
        do_reset();
        stream(16'b1011, 4, 1'b0);
        stream(16'b011, 3, 1'b1);
        check("switch_found_n", 32'(n_found), 32'd1);
        stream(16'b011, 3, 1'b1);
        check("switch_found_n2", 32'(n_found), 32'd2);

        // Reset mid-stream coincident with a valid beat.
        do_reset();
        stream(16'b101, 3, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0000);
        n_found = 0;
        check("mid_rst_window", 32'(window), 32'd0);
        beat(1'b1, 1'b1);
        check("mid_rst_single", 32'(n_found), 32'd0);
        stream(16'b1011, 4, 1'b1);
        check("mid_rst_found_n", 32'(n_found), 32'd1);
        check("mid_rst_count", 32'(match_count), 32'd1);

`ifdef SEQ_DETECT_PROG_PATTERN_EN
        // Programmable pattern.
        do_reset();
        stream(16'b10, 2, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        stream(16'b0110, 4, 1'b1);
        check("prog_found_n", 32'(n_found), 32'd1);
        stream(16'b1011, 4, 1'b1);
        check("prog_old_pat", 32'(n_found), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1011);
        check("prog_load_keep", 32'(match_count), 32'd1);
`endif

        idle(1'b0);
        if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
